bus_read_sequencer: RTL and testbench
=====================================

Name: bus_read_sequencer

Overview:
- Read-side master of the shared register bus in the MIPS datapath.
- Several register_oe instances drive a common WIDTH-bit bus via their output enables.
- On a request naming a source register, this block asserts exactly one one-hot output enable, waits a settle time, captures the bus, and returns the value over a valid/ready response handshake.

Parameters:
- WIDTH, 4, bus/data width in bits.
- NSRC, 4, number of bus sources (output-enable lines).
- SRC_BITS, 2, width of the source index; 2^SRC_BITS >= NSRC.
- SETTLE, 1, extra cycles the enable is held before sampling (>= 0).

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  read request present.
- req_ready  out  1  sequencer can accept a request.
- req_src  in  SRC_BITS  index of the source register to read.
- bus_in  in  WIDTH  shared bus (the outputs of the register_oe instances).
- src_enable  out  NSRC  one-hot output-enable lines to the sources.
- rsp_valid  out  1  response data valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  WIDTH  captured bus value.
- rsp_err  out  1  request named a nonexistent source.

Behaviour:
- Reset (async, active-high): state=IDLE; src_enable=0; rsp_valid=0; rsp_data=0; rsp_err=0; internal src/count cleared. Outputs go to these values immediately, without waiting for a clock edge.
- Reset mid-operation: src_enable drops to 0 at once and any in-flight request is discarded without a response.
- Outputs src_enable, rsp_valid, rsp_data and rsp_err are registered.
- req_ready = (state==IDLE), combinational from state.
- States: IDLE, DRIVE, RESP.
- IDLE: accept a request on an edge with req_valid && req_ready, and latch req_src.
  - req_src >= NSRC: go to RESP with rsp_err=1, rsp_data=0, and no enable ever asserted.
  - Otherwise: go to DRIVE, set src_enable[req_src]=1, and set count=SETTLE.
- DRIVE: src_enable holds the single one-hot bit.
  - count>0: decrement count each edge.
  - count==0 at an edge: capture rsp_data<=bus_in, set rsp_err=0, clear src_enable, set rsp_valid=1, go to RESP.
  - DRIVE therefore lasts SETTLE+1 cycles.
- RESP: rsp_valid=1, and rsp_data/rsp_err stay stable until the handshake. On an edge with rsp_ready, go to IDLE with rsp_valid=0; rsp_data keeps its value.
- Latency, request accepted at edge E0:
  - src_enable is high from E0 to E(SETTLE+1).
  - The bus is sampled at edge E(SETTLE+1).
  - rsp_valid is high from E(SETTLE+1).
  - With SETTLE=1: enable is high 2 cycles and data is available 2 cycles after acceptance.
- Invalid-source latency: rsp_valid is high 1 cycle after acceptance.
- Throughput: at most one outstanding request. Back-to-back requests see at least one IDLE cycle after the response handshake, because req_ready=0 in RESP.
- Invariants:
  - popcount(src_enable) <= 1 at all times.
  - src_enable is 0 in IDLE and RESP.
  - A request arriving while req_ready=0 is ignored; the requester must hold it.
  - rsp_ready while rsp_valid=0 has no effect.
- Width rule: rsp_data is a plain WIDTH-bit copy of bus_in with no extension or truncation.

Test Plan:
- Reset: assert reset mid-cycle while the sequencer is busy → src_enable=0, rsp_valid=0, rsp_data=0, req_ready=1 before the next edge; nothing changes while reset is held.
- Basic read: WIDTH=4, NSRC=4, SETTLE=1, register_oe #2 loaded with 4'b1010; req_src=2 with rsp_ready=1 → src_enable=4'b0100 for exactly 2 cycles, then rsp_valid=1 with rsp_data=4'b1010, rsp_err=0, then back to IDLE.
- Response backpressure: as above but hold rsp_ready=0 for 3 cycles → rsp_valid stays 1 and rsp_data stays 4'b1010, src_enable=0 throughout, req_ready=0; raise rsp_ready → IDLE on the next edge.
- Invalid source: NSRC=3, req_src=3 → src_enable never nonzero; rsp_valid=1 one cycle after acceptance with rsp_err=1, rsp_data=0.
- Busy/back-to-back: issue req_src=0 (value 4'b0101) then hold req_src=1 (value 4'b0011) with req_valid=1 throughout → second request accepted only after the first handshake; responses are 4'b0101 then 4'b0011; check popcount(src_enable)<=1 every cycle.
- Reset mid-DRIVE: assert reset while src_enable=4'b0010 → enable clears asynchronously; no response is issued after reset release; a new request to source 1 completes normally.

Source files
------------

// File: rtl/bus_read_sequencer.sv
// bus_read_sequencer: reads one source off the shared register bus via a one-hot output enable
module bus_read_sequencer #(
    parameter int WIDTH    = 4,
    parameter int NSRC     = 4,
    parameter int SRC_BITS = 2,
    parameter int SETTLE   = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SRC_BITS-1:0] req_src,
    input  logic [WIDTH-1:0]    bus_in,
    output logic [NSRC-1:0]     src_enable,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_data,
    output logic                rsp_err
);
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
    localparam logic [SRC_BITS:0] NSRC_C = (SRC_BITS + 1)'(NSRC);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]          state;
    logic [SRC_BITS-1:0] src;
    logic [CW-1:0]       count;
    logic                src_ok;

    function automatic logic [NSRC-1:0] onehot(input logic [SRC_BITS-1:0] i);
        return NSRC'(1) << i;
    endfunction

    assign req_ready = (state == IDLE);
    assign src_ok    = {1'b0, req_src} < NSRC_C;

    // Accept a request, hold the enable for SETTLE+1 cycles, sample the bus, then hand the value over
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            src        <= '0;
            count      <= '0;
            src_enable <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    src <= req_src;
                    if (src_ok) begin
                        state      <= DRIVE;
                        src_enable <= onehot(req_src);
                        count      <= SETTLE_C;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                    end
                end
                DRIVE: if (count != '0) begin
                    count      <= count - CW'(1);
                    src_enable <= onehot(src);
                end else begin
                    rsp_data   <= bus_in;
                    rsp_err    <= 1'b0;
                    src_enable <= '0;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    src_enable <= '0;
                    rsp_valid  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_read_sequencer.sv
// tb_bus_read_sequencer: directed checks of the bus read sequencer against three modelled sources
module tb_bus_read_sequencer;
    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_src;
    logic [3:0] bus_in;
    logic [2:0] src_enable;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_err;
    logic [3:0] vals [3];
    int         tests = 0;
    int         fails = 0;
    int         n;

    bus_read_sequencer #(.WIDTH(4), .NSRC(3), .SRC_BITS(2), .SETTLE(1)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .bus_in(bus_in), .src_enable(src_enable), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clock = ~clock;

    // Register_oe sources: each drives its value only while its enable is high
    always_comb begin
        bus_in = '0;
        for (int i = 0; i < 3; i++) if (src_enable[i]) bus_in |= vals[i];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        chk("rsp_seen", rsp_valid, 1);
    endtask

    // At most one enable may be high at any sample point
    always @(negedge clock) chk("onehot", 32'($countones(src_enable) <= 1), 1);

    initial begin
        vals[0] = 4'b0101;
        vals[1] = 4'b0011;
        vals[2] = 4'b1010;
        reset = 1'b1; req_valid = 1'b0; req_src = 2'd0; rsp_ready = 1'b0;
        repeat (2) tick();
        chk("rst_en", src_enable, 3'b000);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 4'h0);
        chk("rst_err", rsp_err, 0);
        chk("rst_ready", req_ready, 1);
        reset = 1'b0;
        tick();

        rsp_ready = 1'b1; req_valid = 1'b1; req_src = 2'd2;
        chk("rd_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("rd_en0", src_enable, 3'b100);
        chk("rd_valid0", rsp_valid, 0);
        chk("rd_busy", req_ready, 0);
        tick();
        chk("rd_en1", src_enable, 3'b100);
        chk("rd_valid1", rsp_valid, 0);
        tick();
        chk("rd_en2", src_enable, 3'b000);
        chk("rd_valid2", rsp_valid, 1);
        chk("rd_data", rsp_data, 4'b1010);
        chk("rd_err", rsp_err, 0);
        chk("rd_resp_busy", req_ready, 0);
        tick();
        chk("rd_done", rsp_valid, 0);
        chk("rd_idle", req_ready, 1);
        chk("rd_hold", rsp_data, 4'b1010);

        rsp_ready = 1'b0; req_valid = 1'b1; req_src = 2'd2;
        tick();
        req_valid = 1'b0;
        repeat (2) tick();
        chk("bp_valid", rsp_valid, 1);
        repeat (3) begin
            tick();
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_data", rsp_data, 4'b1010);
            chk("bp_en", src_enable, 3'b000);
            chk("bp_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release", rsp_valid, 0);
        chk("bp_idle", req_ready, 1);

        rsp_ready = 1'b0; req_valid = 1'b1; req_src = 2'd3;
        tick();
        req_valid = 1'b0;
        chk("inv_en", src_enable, 3'b000);
        chk("inv_valid", rsp_valid, 1);
        chk("inv_err", rsp_err, 1);
        chk("inv_data", rsp_data, 4'h0);
        rsp_ready = 1'b1;
        tick();
        chk("inv_done", rsp_valid, 0);
        chk("inv_en_after", src_enable, 3'b000);

        req_valid = 1'b1; req_src = 2'd0;
        tick();
        req_src = 2'd1;
        wait_rsp(n);
        chk("b2b_lat0", n, 2);
        chk("b2b_data0", rsp_data, 4'b0101);
        chk("b2b_err0", rsp_err, 0);
        tick();
        chk("b2b_gap_valid", rsp_valid, 0);
        chk("b2b_gap_ready", req_ready, 1);
        chk("b2b_gap_en", src_enable, 3'b000);
        tick();
        req_valid = 1'b0;
        chk("b2b_en1", src_enable, 3'b010);
        wait_rsp(n);
        chk("b2b_lat1", n, 2);
        chk("b2b_data1", rsp_data, 4'b0011);
        tick();
        chk("b2b_done", rsp_valid, 0);

        vals[1] = 4'b0110;
        req_valid = 1'b1; req_src = 2'd1;
        tick();
        req_valid = 1'b0;
        chk("mr_en", src_enable, 3'b010);
        #3 reset = 1'b1;
        #1;
        chk("mr_async_en", src_enable, 3'b000);
        chk("mr_async_valid", rsp_valid, 0);
        chk("mr_async_data", rsp_data, 4'h0);
        chk("mr_async_ready", req_ready, 1);
        tick();
        chk("mr_held_en", src_enable, 3'b000);
        chk("mr_held_valid", rsp_valid, 0);
        chk("mr_held_data", rsp_data, 4'h0);
        reset = 1'b0;
        repeat (4) begin
            tick();
            chk("mr_no_rsp", rsp_valid, 0);
        end
        req_valid = 1'b1; req_src = 2'd1;
        tick();
        req_valid = 1'b0;
        wait_rsp(n);
        chk("mr_lat", n, 2);
        chk("mr_data", rsp_data, 4'b0110);
        chk("mr_err", rsp_err, 0);
        tick();
        chk("mr_done", rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
